substitution_layer_seq: RTL

- Iterative ASCON substitution layer (p_S), the stage directly downstream of constant_addition inside the permutation round.
- Applies the ASCON 5-bit S-box to all 64 bit-columns of the 320-bit state, COLS_PER_CYCLE columns per clock, trading area for latency.
- Uses a start/busy/done handshake so the round controller can sequence it between constant addition and linear diffusion.

---
 rtl/substitution_layer_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/substitution_layer_seq.sv
// Iterative ASCON substitution layer: applies the 5-bit S-box to all
// 64 bit-columns of the 320-bit state, COLS_PER_CYCLE columns per clock.
//
// Ports:
//   clock_i  rising-edge clock
//   reset_i  synchronous active-high reset
//   start_i  request, sampled only while idle
//   state_i  5x64 state, captured on an accepted start
//   state_o  working/result register
//   busy_o   high while columns are being substituted
//   done_o   one-cycle pulse; state_o then holds the result

package substitution_layer_pkg;
    typedef logic [4:0][63:0] type_state;
endpackage

module substitution_layer_seq
    import substitution_layer_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 8
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      start_i,
    input  type_state state_i,
    output type_state state_o,
    output logic      busy_o,
    output logic      done_o
);

    localparam int NB_STEPS = 64 / COLS_PER_CYCLE;
    localparam int CNT_W    = (NB_STEPS > 1) ? $clog2(NB_STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NB_STEPS - 1);

    generate
        if (COLS_PER_CYCLE != 1  && COLS_PER_CYCLE != 2  &&
            COLS_PER_CYCLE != 4  && COLS_PER_CYCLE != 8  &&
            COLS_PER_CYCLE != 16 && COLS_PER_CYCLE != 32 &&
            COLS_PER_CYCLE != 64) begin : g_bad_cols
            $error("COLS_PER_CYCLE must be a power of two in 1..64");
        end
    endgenerate

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    typedef enum logic {
        IDLE,
        RUN
    } fsm_t;

    fsm_t             fsm_q;
    type_state        state_q;
    type_state        sub_d;
    logic [CNT_W-1:0] step_q;
    logic             busy_q;
    logic             done_q;

    logic [5:0]       col;
    logic [4:0]       sb_in;
    logic [4:0]       sb_out;

    // Substitute only the chunk selected by step_q; every other column
    // passes through untouched. Word 0 supplies the S-box MSB.
    always_comb begin
        sub_d  = state_q;
        col    = '0;
        sb_in  = '0;
        sb_out = '0;
        for (int c = 0; c < COLS_PER_CYCLE; c++) begin
            col    = 6'((int'(step_q) * COLS_PER_CYCLE) + c);
            sb_in  = {state_q[0][col], state_q[1][col], state_q[2][col],
                      state_q[3][col], state_q[4][col]};
            sb_out = SBOX[sb_in];
            sub_d[0][col] = sb_out[4];
            sub_d[1][col] = sb_out[3];
            sub_d[2][col] = sb_out[2];
            sub_d[3][col] = sb_out[1];
            sub_d[4][col] = sb_out[0];
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (fsm_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= state_i;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= sub_d;
                    if (step_q == LAST) begin
                        step_q <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        fsm_q  <= IDLE;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign state_o = state_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
